// File: rtl/full_adder_pkg.sv
// Shared constants for the registered ripple-carry adder.
// The FULL_ADDER_OVF_EN macro (see full_adder_unit) does not affect this package.
package full_adder_pkg;

  localparam int DEFAULT_WIDTH = 1;
  localparam int MAX_WIDTH     = 32;

  // True when an operand width can be elaborated
  function automatic bit width_ok(input int w);
    return (w >= 1) && (w <= MAX_WIDTH);
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Combinational 1-bit full-adder slice: one stage of the ripple-carry chain.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic prop;

  // Propagate term shared by the sum and carry equations
  always_comb begin
    prop = a ^ b;
    sum  = prop ^ cin;
    cout = (a & b) | (cin & prop);
  end

endmodule

// File: rtl/full_adder_unit.sv
// Registered ripple-carry adder: {cout,sum} = a + b + cin, one-cycle latency.
// Valid-qualified: results load only on in_valid, otherwise hold.
// Optional feature: define FULL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module full_adder_unit
  import full_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Refuse to elaborate an out-of-range operand width
  if (!width_ok(WIDTH)) begin : gen_width_check
    $error("full_adder_unit: WIDTH must be in 1..MAX_WIDTH");
  end

  logic [WIDTH-1:0] sum_comb;

  // Carry chain: each slice keeps its own carry-in/carry-out so the chain is
  // expressed stage by stage rather than as a self-referencing vector.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : gen_slice
    logic carry_in;
    logic carry_out;

    if (gi == 0) begin : gen_first
      assign carry_in = cin;
    end else begin : gen_rest
      assign carry_in = gen_slice[gi-1].carry_out;
    end

    full_adder_bit u_bit (
      .a    (a[gi]),
      .b    (b[gi]),
      .cin  (carry_in),
      .sum  (sum_comb[gi]),
      .cout (carry_out)
    );
  end

  logic             cout_comb;
  assign cout_comb = gen_slice[WIDTH-1].carry_out;

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;

`ifdef FULL_ADDER_OVF_EN
  logic ovf_comb;
  logic ovf_q, ovf_d;
  // Two's-complement overflow: carry into the MSB differs from carry out of it
  assign ovf_comb = gen_slice[WIDTH-1].carry_out ^ gen_slice[WIDTH-1].carry_in;
`endif

  // Next-state: load a new result on in_valid, otherwise hold (inputs ignored)
  always_comb begin
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = in_valid;
`ifdef FULL_ADDER_OVF_EN
    ovf_d       = ovf_q;
`endif
    if (in_valid) begin
      sum_d  = sum_comb;
      cout_d = cout_comb;
`ifdef FULL_ADDER_OVF_EN
      ovf_d  = ovf_comb;
`endif
    end
  end

  // Output registers, cleared asynchronously by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef FULL_ADDER_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
`ifdef FULL_ADDER_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;
`ifdef FULL_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder_unit.sv
// Bench for full_adder_unit: a WIDTH=1 and a WIDTH=4 instance share clk/rst.
// Expected results are queued when operands are driven and popped when out_valid is due.
module tb_full_adder_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=1 instance
  logic       iv1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       c1 = 1'b0;
  logic       ov1, co1;
  logic [0:0] s1;

  // WIDTH=4 instance
  logic       iv4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       c4 = 1'b0;
  logic       ov4, co4;
  logic [3:0] s4;
`ifdef FULL_ADDER_OVF_EN
  logic       ovf4, ovf1;
`endif

  full_adder_unit #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .a(a1), .b(b1), .cin(c1),
    .out_valid(ov1), .sum(s1), .cout(co1)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  full_adder_unit #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .a(a4), .b(b4), .cin(c4),
    .out_valid(ov4), .sum(s4), .cout(co4)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(ovf4)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] q1[$];      // {cout,sum}
  logic [5:0] q4[$];      // {ovf,cout,sum}
  logic [1:0] hold1 = '0; // value dut1 outputs should currently show
  logic [5:0] hold4 = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive1(input logic v, input logic [0:0] a, input logic [0:0] b, input logic c);
    logic [1:0] r;
    iv1 = v; a1 = a; b1 = b; c1 = c;
    if (v && !rst) begin
      r = {1'b0, a} + {1'b0, b} + {1'b0, c};
      q1.push_back(r);
    end
  endtask

  task automatic drive4(input logic v, input logic [3:0] a, input logic [3:0] b, input logic c);
    logic [4:0] r;
    logic       o;
    iv4 = v; a4 = a; b4 = b; c4 = c;
    if (v && !rst) begin
      r = {1'b0, a} + {1'b0, b} + {4'b0, c};
      o = (a[3] == b[3]) && (r[3] != a[3]);
      q4.push_back({o, r});
    end
  endtask

  // Advance one clock and check both instances against the scoreboard
  task automatic cycle(input string tag);
    logic p1, p4;
    p1 = iv1 && !rst;
    p4 = iv4 && !rst;
    @(posedge clk);
    #1;
    check({tag, ".v1"}, ov1, p1);
    check({tag, ".v4"}, ov4, p4);
    if (p1) begin
      if (q1.size() > 0) hold1 = q1.pop_front();
      else check({tag, ".q1_empty"}, 1, 0);
    end
    if (p4) begin
      if (q4.size() > 0) hold4 = q4.pop_front();
      else check({tag, ".q4_empty"}, 1, 0);
    end
    check({tag, ".r1"}, {co1, s1}, hold1);
    check({tag, ".r4"}, {co4, s4}, hold4[4:0]);
`ifdef FULL_ADDER_OVF_EN
    check({tag, ".ovf4"}, ovf4, hold4[5]);
`endif
    $display("[TB] %s: v1=%0b cs1=%0b%0b | v4=%0b cout4=%0b sum4=%0h", tag, ov1, co1, s1, ov4, co4, s4);
  endtask

  task automatic assert_reset();
    rst = 1'b1;
    q1.delete();
    q4.delete();
    hold1 = '0;
    hold4 = '0;
  endtask

  initial begin
    // Async reset with random operands presented: outputs clear before any edge
    #1;
    drive1(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drive4(1'b1, 4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
    assert_reset();
    #1;
    check("reset_imm", {ov1, co1, s1, ov4, co4, s4}, 0);
    $display("[TB] reset asserted: v1=%0b v4=%0b sum4=%0h", ov1, ov4, s4);
    cycle("reset_held");
    rst = 1'b0;

    // WIDTH=1 exhaustive, with random traffic on the 4-bit instance
    for (int i = 0; i < 8; i++) begin
      logic [2:0] abc;
      abc = 3'(i);
      drive1(1'b1, abc[2], abc[1], abc[0]);
      drive4(1'b1, 4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
      cycle($sformatf("exh%0d", i));
    end

    // Wrap-around corners
    drive1(1'b0, 1'b0, 1'b0, 1'b0);
    drive4(1'b1, 4'hF, 4'h0, 1'b1);
    cycle("wrap_f0");
    check("wrap_f0.sum", s4, 4'h0);
    check("wrap_f0.cout", co4, 1'b1);
    drive4(1'b1, 4'hF, 4'hF, 1'b1);
    cycle("wrap_ff");
    check("wrap_ff.sum", s4, 4'hF);
    check("wrap_ff.cout", co4, 1'b1);

    // Hold: result 7, then X operands with in_valid low must not disturb it
    drive4(1'b1, 4'h3, 4'h4, 1'b0);
    cycle("hold_load");
    drive1(1'b0, 1'bx, 1'bx, 1'bx);
    drive4(1'b0, 4'bx, 4'bx, 1'bx);
    cycle("hold_idle0");
    cycle("hold_idle1");
    check("hold.sum", s4, 4'h7);

    // Reset mid-stream: operands presented, rst arrives before the edge
    drive4(1'b1, 4'h5, 4'h6, 1'b0);
    #1;
    assert_reset();
    #1;
    check("midrst_imm", {ov4, co4, s4}, 0);
    cycle("midrst_edge");
    rst = 1'b0;
    drive4(1'b0, 4'h0, 4'h0, 1'b0);
    cycle("post_rst_idle");
    drive4(1'b1, 4'h5, 4'h6, 1'b0);
    cycle("post_rst_first");
    check("post_rst.sum", s4, 4'hB);

    // Signed-overflow corners (ovf itself compared only when the port exists)
    drive4(1'b1, 4'h7, 4'h1, 1'b0);
    cycle("ovf_pos");
    check("ovf_pos.sum", s4, 4'h8);
    drive4(1'b1, 4'h8, 4'h8, 1'b0);
    cycle("ovf_neg");
    check("ovf_neg.cout", co4, 1'b1);

    // Random burst with random valid gaps on both instances
    for (int i = 0; i < 24; i++) begin
      drive1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      drive4(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
      cycle($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
